// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-nop and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a main entry plus a one-word skid entry with registered in_ready.
module pipe_stage_reg #(
  parameter int          DATA_W   = 96,
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic in_fire;
  logic out_fire;
  logic stall;

  assign out_fire = out_valid & out_ready;
  assign in_fire  = in_valid & in_ready;
  assign stall    = in_valid & ~in_ready & ~flush;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [31:0]       skid_pc;
  logic [31:0]       skid_instr;
  logic [DATA_W-1:0] skid_data;
  logic              in_ready_q;

  // in_ready_q always mirrors ~skid_valid; flush only masks it for the current cycle.
  assign in_ready = in_ready_q & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid  <= 1'b0;
      out_pc     <= PC_RESET;
      out_instr  <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else if (skid_valid) begin
      if (out_fire) begin
        out_pc     <= skid_pc;
        out_instr  <= skid_instr;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end
    end else if (!out_valid || out_fire) begin
      if (in_fire) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        out_instr <= in_instr;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_instr <= in_instr;
      skid_data  <= in_data;
      in_ready_q <= 1'b0;
    end
  end
`else
  assign in_ready = (~out_valid | out_ready) & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      out_pc    <= PC_RESET;
      out_instr <= '0;
      out_data  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_instr <= in_instr;
      out_data  <= in_data;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // Flush does not clear the stall history; only reset does.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios followed by randomized traffic.
module tb_pipe_stage_reg;
  localparam int          DW  = 96;
  localparam int          CW  = 4;
  localparam logic [31:0] PCR = 32'h0000_3000;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  pipe_stage_reg #(.DATA_W(DW), .PC_RESET(PCR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [64+DW-1:0] word_t;
  word_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int exp_stall = 0;
  bit nop_exp = 1'b1;
  bit exp_rdy = 1'b0;
  int in_fires = 0;
  int out_fires = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the stage contents held in the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
`ifdef PIPE_STAGE_SKID_EN
      exp_rdy = !flush && (sb.size() < CAP);
`else
      exp_rdy = !flush && ((sb.size() == 0) || out_ready);
`endif
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, sb.size() > 0);
      check("stall_cnt", stall_cnt, exp_stall);
      if (out_valid) begin
        if (sb.size() == 0) check("unexpected_word", out_valid, 1'b0);
        else check("payload", {out_pc, out_instr, out_data}, sb[0]);
      end else if (nop_exp) begin
        check("nop_payload", {out_pc, out_instr, out_data}, {PCR, 32'h0, {DW{1'b0}}});
      end
      if (out_valid && out_ready) begin
        out_fires++;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      if (in_valid && in_ready && !flush) in_fires++;
    end
  end

  // Reference model: accepted words enter the scoreboard; reset/flush empty it.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      sb.delete();
      exp_stall = 0;
      nop_exp = 1'b1;
    end else if (flush) begin
      sb.delete();
      nop_exp = 1'b1;
    end else begin
      if (in_valid && !exp_rdy && exp_stall < (2**CW - 1)) exp_stall++;
      if (in_valid && in_ready) begin
        sb.push_back({in_pc, in_instr, in_data});
        nop_exp = 1'b0;
      end
    end
  end

  task automatic drive(input bit v, input bit ordy, input bit fl, input bit rst);
    @(posedge clk);
    #1;
    reset     = rst;
    flush     = fl;
    in_valid  = v;
    out_ready = ordy;
    in_pc     = $urandom;
    in_instr  = $urandom;
    in_data   = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000 required");
    $fatal(1);
  end

  initial begin
    int i0;
    int o0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr = '0; in_data = '0;
    drive(0, 1, 0, 1);
    drive(0, 1, 0, 1);
    drive(0, 1, 0, 0);

    drive(1, 1, 0, 0);
    in_pc = 32'h0000_3004;
    in_instr = 32'h8C01_0004;
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);

    o0 = out_fires;
    for (int k = 0; k < 8; k++) drive(1, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    check("stream_fires", out_fires - o0, 8);

    i0 = in_fires;
    for (int k = 0; k < 5; k++) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("accepted_when_blocked", in_fires - i0, CAP);

    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    for (int k = 0; k < 22; k++) drive(1, 0, 0, 0);
    @(negedge clk);
    #2;
    check("stall_saturated", stall_cnt, 4'd15);

    drive(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 0);

    for (int k = 0; k < 3000; k++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);

    for (int k = 0; k < 4; k++) drive(0, 1, 0, 0);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, giving the payload width (EXTout, Rsout and Rtout concatenated).
REQ-002 The block SHALL have parameter PC_RESET, default 32'h0000_3000, giving the PC value loaded on reset and on flush.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the stall counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous bubble insert that discards stage contents.
REQ-007 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_pc (input, 32), in_instr (input, 32) and in_data (input, DATA_W): the upstream handshake and payload.
REQ-008 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_pc (output, 32), out_instr (output, 32) and out_data (output, DATA_W): the downstream handshake and payload.
REQ-009 The block SHALL have port stall_cnt, output, CNT_W bits: a saturating count of upstream stall cycles.

Function
REQ-010 An upstream transfer (in_fire) SHALL occur in a cycle with in_valid=1, in_ready=1 and flush=0; a downstream transfer (out_fire) SHALL occur in a cycle with out_valid=1 and out_ready=1.
REQ-011 Latency SHALL be one cycle: a word accepted into an empty stage appears on the out_* ports with out_valid=1 on the next cycle.
REQ-012 The out_* payload SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 Words SHALL leave in acceptance order, with none lost or duplicated (barring flush).
REQ-014 A word that is not accepted SHALL NOT alter any payload register.
REQ-015 When flush=1, on the next edge out_valid SHALL become 0, all buffered entries SHALL be discarded, out_pc SHALL become PC_RESET, and out_instr and out_data SHALL become 0 (nop).
REQ-016 in_ready SHALL be 0 in any cycle with flush=1, and any in_valid in that cycle SHALL be dropped.
REQ-017 Precedence SHALL be reset, then flush, then normal handshake.
REQ-018 When out_fire and in_fire occur in the same cycle on a full single entry, the new word SHALL replace the old with no bubble.
REQ-019 stall_cnt SHALL increment by 1 in each cycle with in_valid=1, in_ready=0 and flush=0.
REQ-020 stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-021 On reset, out_valid SHALL be 0, out_pc SHALL be PC_RESET, out_instr and out_data SHALL be 0, all skid entries SHALL be empty, and stall_cnt SHALL be 0.
REQ-022 Reset asserted mid-transfer SHALL discard all words with no partial output.
REQ-023 in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-024 With macro PIPE_STAGE_SKID_EN defined, the block SHALL contain a main entry plus a one-word skid entry.
REQ-025 With PIPE_STAGE_SKID_EN defined, in_ready SHALL be registered and equal to NOT skid_full, independent of out_ready in that cycle.
REQ-026 With PIPE_STAGE_SKID_EN defined, a word accepted while main is full and out_ready=0 SHALL go to skid, and on the next out_fire skid SHALL move to main.
REQ-027 With PIPE_STAGE_SKID_EN undefined, the block SHALL have a single entry and in_ready SHALL equal (NOT out_valid OR out_ready) AND NOT flush, combinationally.

Verification
REQ-028 Reset, then in_valid=1 with in_pc=0x3004, in_instr=0x8C010004 and out_ready=1 SHALL give, next cycle, out_valid=1, out_pc=0x3004 and out_instr=0x8C010004.
REQ-029 Streaming 8 words with out_ready held at 1 SHALL give 8 consecutive out_fire cycles in order, with no bubbles.
REQ-030 With out_ready=0 and 3 words offered, SKID_EN SHALL accept 2 words and stall_cnt SHALL increment each cycle thereafter; without SKID_EN, 1 word SHALL be accepted.
REQ-031 Flush while full (SKID_EN, both entries full) SHALL give, next cycle, out_valid=0, out_pc=0x3000, out_instr=0 and in_ready=1.
REQ-032 With CNT_W=4 and in_valid held for 20 stalled cycles, stall_cnt SHALL stop at 15.
REQ-033 Reset asserted while out_valid=1 and out_ready=0 SHALL give, next cycle, out_valid=0 and stall_cnt=0, and no stale word SHALL appear later.
